// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: main-control decode for the 5-stage RV32I core plus the
// ID/EX, EX/MEM and MEM/WB control registers, hazard detection and operand
// forward selects.
// Optional feature macro: CTRL_PIPELINE_FWD_EN
//   defined   -> EX operand forwarding from MEM/WB, stall only on load-use
//   undefined -> forward selects tied to 00, stall on any RAW against EX/MEM

module ctrl_pipeline #(
    parameter int INST_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_W-1:0]     id_inst,
    input  logic                  id_valid,
    input  logic                  ex_flush,
    input  logic                  mem_stall,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jal_mode,
    output logic                  ex_jalr_mode,
    output logic [1:0]            ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_mem2reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;

    typedef struct packed {
        logic                  valid;
        logic                  alu_src;
        logic                  branch;
        logic                  jal_mode;
        logic                  jalr_mode;
        logic [1:0]            aluop;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic [1:0]            mem2reg;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic [1:0]            mem2reg;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [1:0]            mem2reg;
        logic [REG_ADDR_W-1:0] rd;
    } memwb_t;

    idex_t  dec;
    idex_t  idex;
    exmem_t exmem;
    memwb_t memwb;
    logic   use_rs1;
    logic   use_rs2;
    logic   ex_hit;
    logic   load_use;
    logic   [6:0] opcode;

    // Decoder only looks at opcode and register fields; the rest of the word
    // belongs to the datapath.
    logic unused_inst;
    assign unused_inst = ^id_inst;
    assign opcode = id_inst[6:0];

    // Decode the ID instruction into a control bundle; everything stays 0 for an empty slot
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (id_valid) begin
            dec.valid = 1'b1;
            dec.rs1   = REG_ADDR_W'(id_inst[19:15]);
            dec.rs2   = REG_ADDR_W'(id_inst[24:20]);
            dec.rd    = REG_ADDR_W'(id_inst[11:7]);
            case (opcode)
                OPC_LOAD: begin
                    dec.alu_src   = 1'b1;
                    dec.mem2reg   = 2'b01;
                    dec.reg_write = 1'b1;
                    dec.mem_read  = 1'b1;
                end
                OPC_LOAD_FP: begin
                    dec.mem2reg   = 2'b01;
                end
                OPC_STORE: begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                end
                OPC_OP_IMM: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.aluop     = 2'b10;
                end
                OPC_OP: begin
                    dec.reg_write = 1'b1;
                    dec.aluop     = 2'b10;
                end
                OPC_LUI: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.aluop     = 2'b11;
                end
                OPC_AUIPC: begin
                    dec.mem2reg   = 2'b10;
                    dec.reg_write = 1'b1;
                    dec.aluop     = 2'b11;
                end
                OPC_BRANCH: begin
                    dec.aluop     = 2'b01;
                    dec.branch    = 1'b1;
                end
                OPC_JAL: begin
                    dec.mem2reg   = 2'b11;
                    dec.reg_write = 1'b1;
                    dec.aluop     = 2'b11;
                    dec.jal_mode  = 1'b1;
                end
                OPC_JALR: begin
                    dec.alu_src   = 1'b1;
                    dec.mem2reg   = 2'b11;
                    dec.reg_write = 1'b1;
                    dec.jalr_mode = 1'b1;
                end
                default: begin
                end
            endcase
            if (dec.rd == '0) begin
                dec.reg_write = 1'b0;
            end
            use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
            use_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
        end
    end

    // Detect a RAW hit of the ID operands against the EX producer (and MEM without forwarding)
    always_comb begin
        ex_hit = idex.valid && idex.reg_write && (idex.rd != '0) &&
                 ((use_rs1 && idex.rd == dec.rs1) || (use_rs2 && idex.rd == dec.rs2));
`ifdef CTRL_PIPELINE_FWD_EN
        load_use = ex_hit && idex.mem_read;
`else
        load_use = ex_hit ||
                   (exmem.valid && exmem.reg_write && (exmem.rd != '0) &&
                    ((use_rs1 && exmem.rd == dec.rs1) || (use_rs2 && exmem.rd == dec.rs2)));
`endif
    end

    assign stall_id = !rst && (mem_stall || (load_use && !ex_flush));

    // Advance the control registers: reset, then memory stall, then flush/load-use bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else if (mem_stall) begin
            memwb <= '0;
        end else begin
            exmem.valid     <= idex.valid;
            exmem.mem_read  <= idex.mem_read;
            exmem.mem_write <= idex.mem_write;
            exmem.reg_write <= idex.reg_write;
            exmem.mem2reg   <= idex.mem2reg;
            exmem.rd        <= idex.rd;
            memwb.valid     <= exmem.valid;
            memwb.reg_write <= exmem.reg_write;
            memwb.mem2reg   <= exmem.mem2reg;
            memwb.rd        <= exmem.rd;
            if (ex_flush || load_use) begin
                idex <= '0;
            end else begin
                idex <= dec;
            end
        end
    end

    // Select EX operand sources; the younger MEM result wins over WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
`ifdef CTRL_PIPELINE_FWD_EN
        if (exmem.valid && exmem.reg_write && exmem.rd != '0 && exmem.rd == idex.rs1) begin
            fwd_a = 2'b10;
        end else if (memwb.valid && memwb.reg_write && memwb.rd != '0 && memwb.rd == idex.rs1) begin
            fwd_a = 2'b01;
        end
        if (exmem.valid && exmem.reg_write && exmem.rd != '0 && exmem.rd == idex.rs2) begin
            fwd_b = 2'b10;
        end else if (memwb.valid && memwb.reg_write && memwb.rd != '0 && memwb.rd == idex.rs2) begin
            fwd_b = 2'b01;
        end
`endif
    end

    assign ex_valid     = idex.valid;
    assign ex_alu_src   = idex.alu_src;
    assign ex_branch    = idex.branch;
    assign ex_jal_mode  = idex.jal_mode;
    assign ex_jalr_mode = idex.jalr_mode;
    assign ex_aluop     = idex.aluop;
    assign ex_rs1       = idex.rs1;
    assign ex_rs2       = idex.rs2;
    assign ex_rd        = idex.rd;
    assign mem_valid    = exmem.valid;
    assign mem_read     = exmem.mem_read;
    assign mem_write    = exmem.mem_write;
    assign mem_rd       = exmem.rd;
    assign wb_valid     = memwb.valid;
    assign wb_reg_write = memwb.reg_write;
    assign wb_mem2reg   = memwb.mem2reg;
    assign wb_rd        = memwb.rd;

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipelined main-control unit for the 5-stage RV32I core. It decodes the ID-stage instruction into the control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It detects data hazards and drives the ID stall, and applies branch/jump flushes and data-memory stalls to its own stages. It sits beside the datapath pipeline registers and replaces per-stage combinational decode.

## Interface
- `INST_W`, default 32: instruction width; only bits [31:0] are decoded.
- `REG_ADDR_W`, default 5: register index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_inst`  in  INST_W  instruction in ID (`riscv_inst32_t` layout).
- `id_valid`  in  1  ID holds a real instruction.
- `ex_flush`  in  1  EX redirects the PC (taken branch, JAL, JALR).
- `mem_stall`  in  1  data memory not ready; freezes the pipe.
- `stall_id`  out  1  hold PC and IF/ID this cycle.
- `ex_valid`, `ex_alu_src`, `ex_branch`, `ex_jal_mode`, `ex_jalr_mode`  out  1 each  EX-stage control.
- `ex_aluop`  out  2  EX ALU op class.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  REG_ADDR_W each  EX register indices.
- `mem_valid`, `mem_read`, `mem_write`  out  1 each  MEM-stage control.
- `mem_rd`  out  REG_ADDR_W  MEM destination register.
- `wb_valid`, `wb_reg_write`  out  1 each  WB control.
- `wb_mem2reg`  out  2  WB source select.
- `wb_rd`  out  REG_ADDR_W  WB destination register.
- `fwd_a`, `fwd_b`  out  2 each  EX operand forward selects.

## Operation
- Decode by opcode. Every decoded field is 0 when `id_valid` = 0.
  - `alu_src` = 1 for LOAD, STORE, OP_IMM, JALR, LUI.
  - `mem2reg` = 01 for LOAD and LOAD_FP; 10 for AUIPC; 11 for JAL and JALR; otherwise 00.
  - `reg_write` = 1 for LOAD, OP_IMM, OP, LUI, AUIPC, JAL, JALR. It is forced to 0 when rd = x0.
  - `aluop` = 01 for BRANCH; 11 for LUI, AUIPC, JAL; 10 for OP and OP_IMM; otherwise 00.
  - `mem_read` = LOAD. `mem_write` = STORE.
  - `branch`, `jal_mode` and `jalr_mode` each decode from their own opcode.
  - An unknown opcode produces all-zero controls with valid still set, i.e. a NOP.
- Operand use:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
  - Unused operands never cause a hazard.
- Hazard rule, checked against the ID instruction; hits require a valid producer with reg_write = 1 and rd ≠ 0 whose rd matches a used ID operand:
  - With forwarding, `load_use` fires only when the EX producer has mem_read = 1.
  - Without forwarding, `load_use` fires for any EX or MEM producer.
- Stage update priority, highest first:
  - `rst`: all valid and control registers are cleared to 0.
  - `mem_stall`:
    - ID/EX and EX/MEM hold.
    - MEM/WB loads a bubble (valid = 0, all controls 0).
    - `ex_flush` is ignored; its source holds it asserted until the stall clears.
  - `ex_flush`: ID/EX loads a bubble, killing the ID instruction. EX/MEM and MEM/WB advance normally.
  - `load_use`: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - Otherwise all three registers advance.
- `stall_id` = `mem_stall` | (`load_use` & ~`ex_flush`).
- A bubble zeroes every control field, including rd.

## Timing
- All outputs are registered except `stall_id` and `fwd_a`/`fwd_b`, which are combinational from the current stage registers and `id_inst`.
- Decode-to-EX latency is 1 cycle; WB controls appear 3 cycles after ID in a stall-free pipe.
- Reset values: every output is 0, including `stall_id` while `rst` is high.
- A reset asserted mid-stall or mid-flush takes effect on that same edge. The first post-reset ID instruction enters EX one cycle after `rst` falls.
- `ex_flush` and `load_use` in the same cycle: flush wins and `stall_id` = 0.
- The WB stage is write-first: same-cycle WB/ID use of a register is not a hazard.

## Configuration
- Macro `CTRL_PIPELINE_FWD_EN`.
- Defined:
  - `fwd_a` = 10 when the MEM producer (mem_valid, reg_write, rd ≠ 0) has rd = `ex_rs1`.
  - Otherwise `fwd_a` = 01 when the WB producer has rd = `ex_rs1`; otherwise 00. MEM takes priority over WB.
  - `fwd_b` follows the same rule with `ex_rs2`.
  - The hazard unit stalls on load-use only: one bubble per load-use pair.
- Undefined:
  - `fwd_a` and `fwd_b` are tied to 00.
  - The hazard unit stalls on any RAW against EX or MEM, giving up to 2 bubbles.

## Test plan
- Reset: hold `rst` 2 cycles with a valid OP in ID → all outputs 0; first `ex_valid` = 1 one cycle after `rst` falls.
- `lw x5,0(x1)` then `add x6,x5,x2`, FWD_EN defined → `stall_id` = 1 for exactly 1 cycle, one EX bubble, then `fwd_a` = 01 when the add is in EX.
- `addi x5,x0,1` then `add x6,x5,x5`, FWD_EN undefined → `stall_id` = 1 for 2 cycles; with FWD_EN defined → no stall, `fwd_a` = `fwd_b` = 10.
- `jalr x0,0(x1)` in EX with `ex_flush` = 1 while the ID instruction is a load-use consumer → `stall_id` = 0, next `ex_valid` = 0, `wb_reg_write` for the jalr = 0 because rd = x0.
- `mem_stall` high 3 cycles with a STORE in MEM → `mem_write` stays 1, EX contents unchanged, `wb_valid` = 0 for those 3 cycles, `stall_id` = 1 for those 3 cycles.
